// File: rtl/dp_responder_pkg.sv
// dp_responder_pkg
// Shared constants for the datapath responder: opcode values, instruction
// field positions and widths, the wait-counter width, the LFSR seed and the
// FSM state encoding.
// Configuration macro: DP_RESPONDER_RAND_EN (adds the RAND opcode).
package dp_responder_pkg;

  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_MEMREAD  = 3'd1;
  localparam logic [2:0] OP_MEMWRITE = 3'd2;
  localparam logic [2:0] OP_DRAW     = 3'd3;
  localparam logic [2:0] OP_RAND     = 3'd4;

  localparam int OPCODE_LSB     = 0;
  localparam int OPCODE_W       = 3;
  localparam int ADDR_LSB       = 3;
  localparam int WDATA_LSB      = 11;
  localparam int VGA_X_LSB      = 3;
  localparam int VGA_X_W        = 8;
  localparam int VGA_Y_LSB      = 11;
  localparam int VGA_Y_W        = 7;
  localparam int VGA_COLOUR_LSB = 18;
  localparam int VGA_COLOUR_W   = 3;
  localparam int VGA_PLOT_BIT   = 21;
  localparam int FIELDS_TOP     = 26;

  localparam int WAIT_CNT_W = 3;

  localparam int          LFSR_W    = 16;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MEM_WAIT,
    S_DONE,
    S_ARM
  } state_t;

  // RAND only counts as a real opcode when the LFSR is built in.
  function automatic logic isLegalOpcode(input logic [2:0] op);
    logic legal;
    legal = (op == OP_NOP) || (op == OP_MEMREAD) ||
            (op == OP_MEMWRITE) || (op == OP_DRAW);
`ifdef DP_RESPONDER_RAND_EN
    legal = legal || (op == OP_RAND);
`endif
    return legal;
  endfunction

endpackage

// File: rtl/dp_lfsr.sv
// dp_lfsr
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11, advancing every
// cycle and reseeded with LFSR_SEED on reset.
// Ports: i_clock, i_reset (sync, active high), o_value (current state).
// Only instantiated when DP_RESPONDER_RAND_EN is defined.
module dp_lfsr
  import dp_responder_pkg::*;
(
  input  logic              i_clock,
  input  logic              i_reset,
  output logic [LFSR_W-1:0] o_value
);

  logic [LFSR_W-1:0] r_lfsr;
  logic              w_feedback;

  // Tap numbers are 1-based, so tap 16 is bit 15 and so on.
  assign w_feedback = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[LFSR_W-2:0], w_feedback};
    end
  end

  assign o_value = r_lfsr;

endmodule

// File: rtl/dp_responder.sv
// dp_responder
// Command responder: accepts a command word on a start/finished handshake,
// executes NOP, MEMREAD, MEMWRITE, DRAW (and RAND when enabled), and
// reports the result on o_result_dp.
// Ports:
//   i_clock, i_reset (sync, active high)
//   i_start_dp, i_instruction_dp          command request and word
//   o_finished_dp, o_result_dp            idle flag and last result
//   o_mem_addr, o_mem_wdata, o_mem_wren,
//   i_mem_q                               synchronous RAM port
//   o_vga_x, o_vga_y, o_vga_colour,
//   o_vga_plot                            pixel write port
//   o_err                                 one-cycle illegal-opcode pulse
// Configuration macro: DP_RESPONDER_RAND_EN (adds dp_lfsr and RAND).
module dp_responder
  import dp_responder_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int RESULT_WIDTH      = 16,
  parameter int MEM_ADDR_WIDTH    = 8,
  parameter int MEM_LATENCY       = 2
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_start_dp,
  input  logic [INSTRUCTION_WIDTH-1:0] i_instruction_dp,
  output logic                         o_finished_dp,
  output logic [RESULT_WIDTH-1:0]      o_result_dp,
  output logic [MEM_ADDR_WIDTH-1:0]    o_mem_addr,
  output logic [RESULT_WIDTH-1:0]      o_mem_wdata,
  output logic                         o_mem_wren,
  input  logic [RESULT_WIDTH-1:0]      i_mem_q,
  output logic [VGA_X_W-1:0]           o_vga_x,
  output logic [VGA_Y_W-1:0]           o_vga_y,
  output logic [VGA_COLOUR_W-1:0]      o_vga_colour,
  output logic                         o_vga_plot,
  output logic                         o_err
);

  state_t                         r_state;
  state_t                         w_next_state;
  logic [INSTRUCTION_WIDTH-1:0]   r_instr;
  logic                           r_finished;
  logic [RESULT_WIDTH-1:0]        r_result;
  logic [WAIT_CNT_W-1:0]          r_wait_cnt;

  logic                           w_latch;
  logic                           w_load_result;
  logic [RESULT_WIDTH-1:0]        w_result_next;
  logic                           w_wait_load;
  logic                           w_wait_dec;
  logic [OPCODE_W-1:0]            w_op;
  logic                           w_unused_instr_bits;

  assign w_op = r_instr[OPCODE_LSB +: OPCODE_W];

  // Bits above the last field carry no meaning for any opcode.
  assign w_unused_instr_bits = ^r_instr[INSTRUCTION_WIDTH-1:FIELDS_TOP+1];

`ifdef DP_RESPONDER_RAND_EN
  logic [LFSR_W-1:0] w_lfsr;

  dp_lfsr u_lfsr (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .o_value (w_lfsr)
  );
`endif

  // Next-state logic. The result register is loaded exactly on the edge
  // that enters DONE, which is also where o_finished_dp goes back high.
  always_comb begin
    w_next_state  = r_state;
    w_latch       = 1'b0;
    w_load_result = 1'b0;
    w_result_next = r_result;
    w_wait_load   = 1'b0;
    w_wait_dec    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start_dp) begin
          w_latch      = 1'b1;
          w_next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        w_next_state  = S_DONE;
        w_load_result = 1'b1;
        case (w_op)
          OP_NOP:      w_result_next = '0;
          OP_MEMREAD: begin
            w_load_result = 1'b0;
            w_wait_load   = 1'b1;
            w_next_state  = S_MEM_WAIT;
          end
          OP_MEMWRITE: w_result_next = r_instr[WDATA_LSB +: RESULT_WIDTH];
          OP_DRAW:     w_result_next = '0;
`ifdef DP_RESPONDER_RAND_EN
          OP_RAND:     w_result_next = RESULT_WIDTH'(w_lfsr);
`endif
          default:     w_result_next = '1;
        endcase
      end
      // The address has been on the bus since EXEC, so after loading
      // MEM_LATENCY-1 the zero count lines up with valid read data.
      S_MEM_WAIT: begin
        if (r_wait_cnt == '0) begin
          w_load_result = 1'b1;
          w_result_next = i_mem_q;
          w_next_state  = S_DONE;
        end else begin
          w_wait_dec = 1'b1;
        end
      end
      S_DONE: w_next_state = S_ARM;
      // Hold here until start drops so a long start pulse runs only once.
      S_ARM: begin
        if (!i_start_dp) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State, latched command, handshake flag, result and wait counter.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_instr    <= '0;
      r_finished <= 1'b1;
      r_result   <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_latch) begin
        r_instr    <= i_instruction_dp;
        r_finished <= 1'b0;
      end
      if (w_load_result) begin
        r_result   <= w_result_next;
        r_finished <= 1'b1;
      end
      if (w_wait_load) begin
        r_wait_cnt <= WAIT_CNT_W'(MEM_LATENCY - 1);
      end else if (w_wait_dec && (r_wait_cnt != '0)) begin
        r_wait_cnt <= r_wait_cnt - 1'b1;
      end
    end
  end

  // Data buses follow the latched command (all zero after reset); the
  // strobes are decoded from registers and only fire in EXEC.
  assign o_finished_dp = r_finished;
  assign o_result_dp   = r_result;
  assign o_mem_addr    = r_instr[ADDR_LSB +: MEM_ADDR_WIDTH];
  assign o_mem_wdata   = r_instr[WDATA_LSB +: RESULT_WIDTH];
  assign o_vga_x       = r_instr[VGA_X_LSB +: VGA_X_W];
  assign o_vga_y       = r_instr[VGA_Y_LSB +: VGA_Y_W];
  assign o_vga_colour  = r_instr[VGA_COLOUR_LSB +: VGA_COLOUR_W];
  assign o_mem_wren    = (r_state == S_EXEC) && (w_op == OP_MEMWRITE);
  assign o_vga_plot    = (r_state == S_EXEC) && (w_op == OP_DRAW) &&
                         r_instr[VGA_PLOT_BIT];
  assign o_err         = (r_state == S_EXEC) && !isLegalOpcode(w_op);

endmodule

// File: doc/dp_responder.md
DP_RESPONDER -- requirements
Module: dp_responder

Interface
REQ-001 Parameter INSTRUCTION_WIDTH, 32, width of instruction word.
REQ-002 Parameter RESULT_WIDTH, 16, width of result and memory data.
REQ-003 Parameter MEM_ADDR_WIDTH, 8, memory address width.
REQ-004 Parameter MEM_LATENCY, 2, cycles from mem_addr valid to mem_q valid (1..7).
REQ-005 Port clock  in  1  single clock, all logic on rising edge.
REQ-006 Port reset  in  1  synchronous, active-high reset.
REQ-007 Port start_dp  in  1  command request from initiator.
REQ-008 Port instruction_dp  in  INSTRUCTION_WIDTH  command word; bits [2:0] are the opcode.
REQ-009 Port finished_dp  out  1  high = idle, result valid.
REQ-010 Port result_dp  out  RESULT_WIDTH  result of last command.
REQ-011 Ports mem_addr out MEM_ADDR_WIDTH, mem_wdata out RESULT_WIDTH, mem_wren out 1, mem_q in RESULT_WIDTH  synchronous RAM port.
REQ-012 Ports vga_x out 8, vga_y out 7, vga_colour out 3, vga_plot out 1  pixel write port.
REQ-013 Port err  out  1  one-cycle pulse on illegal opcode.

Function
REQ-014 Opcodes SHALL be: 0 NOP, 1 MEMREAD, 2 MEMWRITE, 3 DRAW, 4 RAND, 5-7 illegal.
REQ-015 Fields: address [10:3]; write data [26:11]; DRAW x [10:3], y [17:11], colour [20:18], plot [21].
REQ-016 States SHALL be IDLE, EXEC, MEM_WAIT, DONE, ARM.
REQ-017 IDLE: finished_dp=1; start_dp sampled 1 -> latch instruction_dp, finished_dp registered 0 on that same edge, go EXEC.
REQ-018 EXEC NOP: result_dp=0, go DONE.
REQ-019 EXEC MEMREAD: drive mem_addr, go MEM_WAIT; after MEM_LATENCY cycles capture mem_q into result_dp, go DONE.
REQ-020 EXEC MEMWRITE: mem_addr, mem_wdata driven, mem_wren high exactly one cycle; result_dp = write data; go DONE.
REQ-021 EXEC DRAW: vga_x/y/colour from fields, vga_plot = plot bit for exactly one cycle; result_dp=0; go DONE.
REQ-022 EXEC illegal opcode: result_dp all ones, err pulses one cycle, go DONE.
REQ-023 DONE: finished_dp=1; go ARM.
REQ-024 ARM: finished_dp=1; return to IDLE only after start_dp sampled 0; a start held high across completion SHALL NOT re-execute.
REQ-025 start_dp while not IDLE SHALL be ignored; latched instruction SHALL NOT change.
REQ-026 result_dp SHALL hold its value from DONE until the next command's completion.
REQ-027 mem_wren, vga_plot, err SHALL be 0 in every state except as in REQ-020..022.
REQ-028 MEM_WAIT counter SHALL be 3 bits, loaded MEM_LATENCY-1, no wrap beyond zero.

Reset
REQ-029 Reset SHALL force IDLE, finished_dp=1, result_dp=0, mem_addr=0, mem_wdata=0, mem_wren=0, vga_*=0, err=0.
REQ-030 Reset mid-command SHALL abort with no further mem_wren or vga_plot pulse.
REQ-031 Reset SHALL load the LFSR seed 16'hACE1 when present.

Configuration
REQ-032 Macro DP_RESPONDER_RAND_EN defined: 16-bit LFSR (taps 16,14,13,11) advances every cycle; RAND returns its current value in result_dp, latency as NOP.
REQ-033 Macro undefined: no LFSR; opcode 4 treated as illegal (REQ-022).

Structure
REQ-034 Opcode values, field bit positions, widths, LFSR seed belong in shared constants.h.
REQ-035 LFSR SHALL be sub-module dp_lfsr, instantiated only under DP_RESPONDER_RAND_EN.

Verification
REQ-036 After reset -> finished_dp=1, result_dp=0, all strobes 0.
REQ-037 Preload mem[0x2A]=16'h1234; MEMREAD 0x2A with start held 2 cycles -> finished_dp low next cycle, result_dp=16'h1234 at DONE, exactly one execution.
REQ-038 MEMWRITE addr 0x05 data 16'hBEEF then MEMREAD 0x05 -> one mem_wren pulse, read returns 16'hBEEF.
REQ-039 DRAW x=10, y=20, colour=3'b101, plot=1 -> single vga_plot pulse with those values; plot=0 -> no pulse.
REQ-040 Opcode 7 -> err one pulse, result_dp=16'hFFFF; start asserted during MEM_WAIT ignored.
REQ-041 Reset asserted in MEM_WAIT -> IDLE next cycle, finished_dp=1, result_dp=0; RAND with macro on returns nonzero, off returns 16'hFFFF.
